// File: rtl/player_input_arbiter_pkg.sv
// Shared types and default register addresses for the player input arbiter.
package player_input_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLocked,
    StCooldown
  } state_e;

  localparam int unsigned NumPlayers = 4;

  localparam logic [15:0] DefaultStatusAdr = 16'hC000;
  localparam logic [15:0] DefaultAckAdr    = 16'hC001;
  localparam logic [15:0] DefaultMaskAdr   = 16'hC002;

endpackage

// File: rtl/button_sync.sv
// One raw button: 2-flop synchronizer followed by a rising-edge detector.
// A button already held when reset releases must be seen low before it can
// produce a press, so an arm flop gates the edge output.
module button_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  // Shifts in ones after reset; bit 1 set means sync2_q holds a real sample.
  logic [1:0] vld_q, vld_d;

  // Next-state for synchronizer, edge history and arming.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
    end
  end

  assign press_o = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/player_input_arbiter.sv
// First-press arbiter for four player buttons with CPU-visible status,
// acknowledge and enable-mask registers plus a post-acknowledge lockout.
module player_input_arbiter
  import player_input_arbiter_pkg::*;
#(
  parameter logic [15:0] STATUS_ADR      = DefaultStatusAdr,
  parameter logic [15:0] ACK_ADR         = DefaultAckAdr,
  parameter logic [15:0] MASK_ADR        = DefaultMaskAdr,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic [15:0] player_data,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        locked,
  output logic [1:0]  first_player
);

  localparam logic [15:0] CntLoad = 16'(COOLDOWN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fp_q, fp_d;
  logic [3:0]  val_q, val_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  mask_q, mask_d;

  logic [NumPlayers-1:0] press;
  logic [NumPlayers-1:0] req;
  logic                  found;
  logic [1:0]            win;
  logic [1:0]            idx;
  logic                  ack_wr;
  logic                  mask_wr;
  logic                  unused_wd;

  assign unused_wd = ^writedata[15:4];

  for (genvar g = 0; g < NumPlayers; g++) begin : g_sync
    button_sync u_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  // Round-robin pick among enabled presses, starting at rr_q and wrapping.
  always_comb begin
    req   = press & mask_q;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < NumPlayers; k++) begin
      idx = rr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign ack_wr  = memwrite && (adr == ACK_ADR);
  assign mask_wr = memwrite && (adr == MASK_ADR);

  // Next-state: FSM, cooldown counter, held winner and mask register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;
    val_d   = val_q;
    rr_d    = rr_q;
    mask_d  = mask_q;

    if (mask_wr) begin
      mask_d = writedata[3:0];
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StLocked;
          fp_d    = win;
          val_d   = player_data[{win, 2'b00} +: 4];
          rr_d    = win + 2'd1;
        end
      end
      StLocked: begin
        // Winner fields are cleared on release so they read zero when unlocked.
        if (ack_wr) begin
          state_d = StCooldown;
          cnt_d   = CntLoad;
          fp_d    = 2'd0;
          val_d   = 4'd0;
        end
      end
      StCooldown: begin
        if (cnt_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      fp_q    <= 2'd0;
      val_q   <= 4'd0;
      rr_q    <= 2'd0;
      mask_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      val_q   <= val_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
    end
  end

  assign locked       = (state_q == StLocked);
  assign first_player = fp_q;
  assign hit          = (adr == STATUS_ADR) || (adr == ACK_ADR) || (adr == MASK_ADR);

  // Combinational read mux for the status and mask registers.
  always_comb begin
    rdata = 16'h0000;
    if (memread && (adr == STATUS_ADR)) begin
      rdata = {locked, 9'b0, fp_q, val_q};
    end else if (memread && (adr == MASK_ADR)) begin
      rdata = {12'b0, mask_q};
    end
  end

endmodule

// File: tb/tb_player_input_arbiter.sv
// Directed bench for player_input_arbiter: a per-cycle vector table for the
// basic press/read/ack flow, then hand sequences for cooldown length,
// round-robin ties, masking and reset with a held button.
module tb_player_input_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic [15:0] player_data;
  logic        memread;
  logic        memwrite;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [15:0] rdata;
  logic        hit;
  logic        locked;
  logic [1:0]  first_player;

  int n_checks = 0;
  int n_fail   = 0;

  player_input_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .player_data (player_data),
    .memread     (memread),
    .memwrite    (memwrite),
    .adr         (adr),
    .writedata   (writedata),
    .rdata       (rdata),
    .hit         (hit),
    .locked      (locked),
    .first_player(first_player)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] pd;
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [15:0] wd;
    logic        exp_locked;
    logic [1:0]  exp_fp;
    logic [15:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    memread   = 1'b0;
    memwrite  = 1'b0;
    adr       = 16'h0000;
    writedata = 16'h0000;
  endtask

  task automatic do_ack();
    memwrite = 1'b1;
    adr      = 16'hC001;
    tick(1);
    memwrite = 1'b0;
    adr      = 16'h0000;
  endtask

  task automatic do_reset();
    btn = 4'b0000;
    idle_bus();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
  endtask

  initial begin
    rst         = 1'b0;
    btn         = 4'b0000;
    player_data = 16'h0000;
    idle_bus();

    // Table: btn, pd, rd, wr, adr, wd | locked, fp, rdata, hit
    vecs[0]  = '{4'b0000, 16'h0000, 1'b0, 1'b1, 16'hC001, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1};
    vecs[1]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 16'hC003, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[2]  = '{4'b0100, 16'h0A00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[3]  = '{4'b0100, 16'h0A00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[4]  = '{4'b0100, 16'h0A00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd2, 16'h0000, 1'b0};
    vecs[5]  = '{4'b0100, 16'h0A00, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 2'd2, 16'h802A, 1'b1};
    vecs[6]  = '{4'b0001, 16'hFFFF, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 2'd2, 16'h802A, 1'b1};
    vecs[7]  = '{4'b0001, 16'hFFFF, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 2'd2, 16'h802A, 1'b1};
    vecs[8]  = '{4'b0001, 16'hFFFF, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 2'd2, 16'h802A, 1'b1};
    vecs[9]  = '{4'b0000, 16'hFFFF, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 2'd2, 16'h802A, 1'b1};
    vecs[10] = '{4'b0000, 16'hFFFF, 1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 2'd2, 16'h000F, 1'b1};
    vecs[11] = '{4'b0000, 16'h0000, 1'b1, 1'b1, 16'hC001, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1};

    // Reset state
    tick(2);
    memread = 1'b1;
    adr     = 16'hC002;
    #1;
    check("reset locked", 16'(locked), 16'h0000);
    check("reset first_player", 16'(first_player), 16'h0000);
    check("reset mask read", rdata, 16'h000F);
    idle_bus();
    rst = 1'b1;
    tick(4);

    for (int i = 0; i < 12; i++) begin
      btn         = vecs[i].btn;
      player_data = vecs[i].pd;
      memread     = vecs[i].rd;
      memwrite    = vecs[i].wr;
      adr         = vecs[i].adr;
      writedata   = vecs[i].wd;
      tick(1);
      check($sformatf("vec%0d locked", i), 16'(locked), 16'(vecs[i].exp_locked));
      check($sformatf("vec%0d first_player", i), 16'(first_player), 16'(vecs[i].exp_fp));
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d hit", i), 16'(hit), 16'(vecs[i].exp_hit));
    end
    idle_bus();

    // Cooldown entered at the last vector's edge; a press landing on its
    // 16th cycle must be dropped.
    tick(13);
    btn = 4'b0001;
    tick(6);
    check("cooldown last-cycle press ignored", 16'(locked), 16'h0000);
    btn = 4'b0000;
    tick(4);

    // Lock player 1, ack, then time a press to land on the first idle cycle.
    btn         = 4'b0010;
    player_data = 16'h00B0;
    memread     = 1'b1;
    adr         = 16'hC000;
    tick(3);
    check("p1 locked", 16'(locked), 16'h0001);
    check("p1 first_player", 16'(first_player), 16'h0001);
    check("p1 status", rdata, 16'h801B);
    btn     = 4'b0000;
    memread = 1'b0;
    do_ack();
    tick(14);
    btn         = 4'b0001;
    player_data = 16'h000C;
    memread     = 1'b1;
    adr         = 16'hC000;
    tick(2);
    check("still cooling at edge 16", 16'(locked), 16'h0000);
    tick(1);
    check("locks on first idle edge", 16'(locked), 16'h0001);
    check("p0 status after cooldown", rdata, 16'h800C);

    // Tie resolution from rr_ptr = 0 then from rr_ptr = 2.
    do_reset();
    btn         = 4'b1010;
    player_data = 16'h5060;
    memread     = 1'b1;
    adr         = 16'hC000;
    tick(3);
    check("tie1 first_player", 16'(first_player), 16'h0001);
    check("tie1 status", rdata, 16'h8016);
    btn     = 4'b0000;
    memread = 1'b0;
    do_ack();
    tick(20);
    btn     = 4'b1010;
    memread = 1'b1;
    adr     = 16'hC000;
    tick(3);
    check("tie2 first_player", 16'(first_player), 16'h0003);
    check("tie2 status", rdata, 16'h8035);
    btn     = 4'b0000;
    memread = 1'b0;
    do_ack();
    tick(20);

    // Mask: only player 0 enabled.
    memwrite  = 1'b1;
    adr       = 16'hC002;
    writedata = 16'h0001;
    tick(1);
    memwrite = 1'b0;
    memread  = 1'b1;
    #1;
    check("mask readback", rdata, 16'h0001);
    memread = 1'b0;
    btn     = 4'b1000;
    tick(5);
    check("masked player 3 ignored", 16'(locked), 16'h0000);
    btn = 4'b0000;
    tick(4);
    btn         = 4'b0001;
    player_data = 16'h0007;
    memread     = 1'b1;
    adr         = 16'hC000;
    tick(3);
    check("enabled player 0 locks", 16'(locked), 16'h0001);
    check("enabled player 0 status", rdata, 16'h8007);

    // Mask write while locked does not release the winner.
    memwrite  = 1'b1;
    adr       = 16'hC002;
    writedata = 16'h0002;
    tick(1);
    memwrite = 1'b0;
    #1;
    check("mask write keeps lock", 16'(locked), 16'h0001);
    check("mask readback locked", rdata, 16'h0002);

    // Asynchronous reset mid-LOCKED with player 0 still held.
    rst = 1'b0;
    #1;
    check("async reset locked", 16'(locked), 16'h0000);
    check("async reset mask", rdata, 16'h000F);
    adr = 16'hC000;
    #1;
    check("async reset status", rdata, 16'h0000);
    tick(2);
    rst = 1'b1;
    tick(8);
    check("held button after reset ignored", 16'(locked), 16'h0000);
    btn = 4'b0000;
    tick(4);
    btn = 4'b0001;
    tick(3);
    check("re-press after reset locks", 16'(locked), 16'h0001);
    check("re-press first_player", 16'(first_player), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_input_arbiter.md
PLAYER_INPUT_ARBITER -- requirements
Module: player_input_arbiter

Interface
REQ-001 Parameter STATUS_ADR, default 16'hC000, memory-mapped status register address (read-only).
REQ-002 Parameter ACK_ADR, default 16'hC001, memory-mapped acknowledge address (write-only, data ignored).
REQ-003 Parameter MASK_ADR, default 16'hC002, memory-mapped player-enable mask (write; writedata[3:0] used).
REQ-004 Parameter COOLDOWN_CYCLES, default 16, lockout length after acknowledge, range 1..65535.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 btn  input  4  raw player buttons, asynchronous to clk; bit i = player i.
REQ-008 player_data  input  16  player value nibbles; [4i+3:4i] = player i.
REQ-009 memread  input  1  CPU read strobe.
REQ-010 memwrite  input  1  CPU write strobe.
REQ-011 adr  input  16  CPU address.
REQ-012 writedata  input  16  CPU write data.
REQ-013 rdata  output  16  status read data.
REQ-014 hit  output  1  high when adr equals STATUS_ADR, ACK_ADR or MASK_ADR; steers the top-level read mux/enable.
REQ-015 locked  output  1  a winner is held awaiting acknowledge.
REQ-016 first_player  output  2  index of held winner.

Function
REQ-017 Each btn bit SHALL pass a 2-flop synchronizer then a rising-edge detector; only edges produce presses (held buttons never re-trigger).
REQ-018 States: IDLE, LOCKED, COOLDOWN.
REQ-019 IDLE: on any press from an enabled player, SHALL latch winner index and player_data nibble of that player, go LOCKED.
REQ-020 Latency: locked SHALL rise after the 3rd rising clk edge counting the edge that first samples btn high.
REQ-021 Simultaneous presses SHALL resolve round-robin: search starts at rr_ptr, ascending, wrapping 3->0; after a win rr_ptr = winner+1 mod 4.
REQ-022 LOCKED: presses SHALL be discarded (not queued); winner and value SHALL be held stable.
REQ-023 LOCKED: memwrite with adr==ACK_ADR SHALL transition to COOLDOWN and load counter with COOLDOWN_CYCLES-1.
REQ-024 ACK writes in IDLE or COOLDOWN SHALL be ignored.
REQ-025 COOLDOWN: counter decrements each cycle; at 0 SHALL return to IDLE (exactly COOLDOWN_CYCLES cycles in COOLDOWN); presses discarded.
REQ-026 memwrite with adr==MASK_ADR SHALL load mask from writedata[3:0] in any state; takes effect next cycle; does not release a held winner.
REQ-027 rdata (combinational) SHALL equal {locked, 9'b0, first_player, value[3:0]} when memread and adr==STATUS_ADR; {12'b0, mask} when memread and adr==MASK_ADR; else 16'h0000.
REQ-028 first_player and value SHALL read 0 whenever locked is 0.
REQ-029 memread and memwrite both high in the same cycle SHALL perform both actions independently.

Reset
REQ-030 rst low SHALL asynchronously force: state IDLE, locked 0, first_player 0, value 0, rr_ptr 0, counter 0, mask 4'hF, synchronizer and edge flops 0.
REQ-031 Reset asserted mid-LOCKED or mid-COOLDOWN SHALL discard the winner; after release a held button SHALL NOT count as a press until released and pressed again.

Structure
REQ-032 Shared package SHALL hold the state enum and default address constants (STATUS_ADR, ACK_ADR, MASK_ADR).
REQ-033 Sub-module button_sync SHALL implement one 2-flop synchronizer plus edge detector, instantiated four times.
REQ-034 Round-robin pick, FSM, counter and register decode SHALL reside in player_input_arbiter.

Verification
REQ-035 Single press: btn=4'b0100, player_data=16'h0A00 -> locked=1 after 3 edges, first_player=2, STATUS read = 16'h802A.
REQ-036 Tie: btn 4'b1010 same cycle, rr_ptr=0 -> winner 1; ack, cooldown, repeat tie -> winner 3.
REQ-037 Lockout: while LOCKED press player 0 -> no change; ack -> exactly 16 cycles COOLDOWN, press during cooldown ignored, then IDLE.
REQ-038 Mask: write MASK_ADR 16'h0001, press player 3 -> stays IDLE; press player 0 -> locked, first_player=0.
REQ-039 Reset mid-LOCKED with btn held high -> all outputs 0, mask=4'hF; no lock until btn falls and rises again.
REQ-040 Spurious ACK in IDLE and read of non-mapped adr -> no state change, rdata=16'h0000, hit=0.
